// File: rtl/sipo_deframer.sv
// Serial-in / parallel-out deframer with a valid/ready word register and a sticky drop flag.
// Optional even-parity check on a trailing frame bit, enabled by SIPO_PARITY_CHECK_EN.
module sipo_deframer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             serial_in,
  input  logic             serial_valid,
  output logic [WIDTH-1:0] parallel_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       bit_cnt,
  output logic             overflow,
  input  logic             ovf_clr,
  output logic             parity_err
);

`ifdef SIPO_PARITY_CHECK_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam logic [4:0] LAST = 5'(FRAME - 1);

  typedef enum logic {S_EMPTY, S_FULL} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt, candidate;
  logic             complete, consume, load, drop, shift_en;

  always_comb begin
    shreg_nxt = shreg;
    if (MSB_FIRST) shreg_nxt = {shreg[WIDTH-2:0], serial_in};
    else           shreg_nxt = {serial_in, shreg[WIDTH-1:1]};
  end

  assign complete = serial_valid && (bit_cnt == LAST);
  assign consume  = (state == S_FULL) && out_ready;
  assign load     = complete && ((state == S_EMPTY) || out_ready);
  assign drop     = complete && !load;

`ifdef SIPO_PARITY_CHECK_EN
  // The parity bit never enters the shift register; the data bits are already in place.
  assign shift_en  = serial_valid && !complete;
  assign candidate = shreg;
`else
  assign shift_en  = serial_valid;
  assign candidate = shreg_nxt;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_EMPTY;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (load)         state_nxt = S_FULL;
    else if (consume) state_nxt = S_EMPTY;
  end

  // Output logic
  always_comb begin
    out_valid = (state == S_FULL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else begin
      if (shift_en) shreg <= shreg_nxt;
      if (serial_valid) bit_cnt <= complete ? 5'd0 : bit_cnt + 5'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       parallel_out <= '0;
    else if (load) parallel_out <= candidate;
  end

  // A drop on the same edge as a clear request keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (ovf_clr) overflow <= 1'b0;
  end

`ifdef SIPO_PARITY_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       parity_err <= 1'b0;
    else if (load) parity_err <= (^shreg) ^ serial_in;
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_deframer.sv
// Directed self-checking bench for sipo_deframer (MSB-first and LSB-first instances).
// Builds with or without SIPO_PARITY_CHECK_EN; frames carry a correct parity bit when enabled.
module tb_sipo_deframer;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       serial_in = 1'b0, serial_valid = 1'b0, out_ready = 1'b0, ovf_clr = 1'b0;
  logic [3:0] parallel_out;
  logic       out_valid, overflow, parity_err;
  logic [4:0] bit_cnt;
  logic       serial_in2 = 1'b0, serial_valid2 = 1'b0, out_ready2 = 1'b0;
  logic [3:0] parallel_out2;
  logic       out_valid2, overflow2, parity_err2;
  logic [4:0] bit_cnt2;
  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  sipo_deframer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst), .serial_in(serial_in), .serial_valid(serial_valid),
    .parallel_out(parallel_out), .out_valid(out_valid), .out_ready(out_ready),
    .bit_cnt(bit_cnt), .overflow(overflow), .ovf_clr(ovf_clr), .parity_err(parity_err));

  sipo_deframer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .serial_in(serial_in2), .serial_valid(serial_valid2),
    .parallel_out(parallel_out2), .out_valid(out_valid2), .out_ready(out_ready2),
    .bit_cnt(bit_cnt2), .overflow(overflow2), .ovf_clr(1'b0), .parity_err(parity_err2));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    serial_in = b;
    serial_valid = 1'b1;
    step();
    serial_valid = 1'b0;
  endtask

  task automatic send_parity(input logic [3:0] w);
`ifdef SIPO_PARITY_CHECK_EN
    send_bit(^w);
`endif
  endtask

  // Sends w MSB first (plus parity when enabled); ready_last raises out_ready on the final frame bit.
  task automatic send_word(input logic [3:0] w, input logic ready_last, input logic clr_last);
    for (int i = 3; i >= 0; i--) begin
`ifndef SIPO_PARITY_CHECK_EN
      if (i == 0) begin
        out_ready = ready_last;
        ovf_clr = clr_last;
      end
`endif
      send_bit(w[i]);
    end
`ifdef SIPO_PARITY_CHECK_EN
    out_ready = ready_last;
    ovf_clr = clr_last;
    send_parity(w);
`endif
    out_ready = 1'b0;
    ovf_clr = 1'b0;
  endtask

  task automatic send_bit2(input logic b);
    serial_in2 = b;
    serial_valid2 = 1'b1;
    step();
    serial_valid2 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    compared++; if (parallel_out !== 4'b0000) begin mismatched++; $display("FAIL reset_po got %b want 0000", parallel_out); end
    compared++; if ({out_valid, overflow, parity_err, bit_cnt} !== 8'h00) begin mismatched++; $display("FAIL reset_flags got %b%b%b cnt %0d want 000 cnt 0", out_valid, overflow, parity_err, bit_cnt); end
    compared++; if ({parallel_out2, out_valid2, bit_cnt2} !== 10'h000) begin mismatched++; $display("FAIL reset_lsb got po %b v %b cnt %0d want 0", parallel_out2, out_valid2, bit_cnt2); end
    rst = 1'b0;
    step();
    send_bit(1'b1); send_bit(1'b0);
    compared++; if (bit_cnt !== 5'd2) begin mismatched++; $display("FAIL midword_cnt got %0d want 2", bit_cnt); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    compared++; if (bit_cnt !== 5'd0) begin mismatched++; $display("FAIL reset_cnt got %0d want 0", bit_cnt); end
    send_word(4'b1011, 1'b0, 1'b0);
    compared++; if (parallel_out !== 4'b1011 || out_valid !== 1'b1) begin mismatched++; $display("FAIL reset_word got %b v %b want 1011 v 1", parallel_out, out_valid); end
    compared++; if (bit_cnt !== 5'd0) begin mismatched++; $display("FAIL reset_word_cnt got %0d want 0", bit_cnt); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    compared++; if (out_valid !== 1'b0 || parallel_out !== 4'b1011) begin mismatched++; $display("FAIL consume got v %b po %b want v 0 po 1011", out_valid, parallel_out); end
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0); send_parity(4'b1100);
    compared++; if (parallel_out !== 4'b1100 || out_valid !== 1'b1) begin mismatched++; $display("FAIL stream_w0 got %b v %b want 1100 v 1", parallel_out, out_valid); end
    send_bit(1'b0);
    compared++; if (out_valid !== 1'b0 || bit_cnt !== 5'd1) begin mismatched++; $display("FAIL stream_gap got v %b cnt %0d want v 0 cnt 1", out_valid, bit_cnt); end
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_parity(4'b0101);
    compared++; if (parallel_out !== 4'b0101 || out_valid !== 1'b1) begin mismatched++; $display("FAIL stream_w1 got %b v %b want 0101 v 1", parallel_out, out_valid); end
    step();
    compared++; if (out_valid !== 1'b0 || overflow !== 1'b0) begin mismatched++; $display("FAIL stream_end got v %b ovf %b want 0 0", out_valid, overflow); end
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    send_word(4'b1010, 1'b0, 1'b0);
    compared++; if (parallel_out !== 4'b1010 || out_valid !== 1'b1 || overflow !== 1'b0) begin mismatched++; $display("FAIL bp_first got %b v %b ovf %b want 1010 1 0", parallel_out, out_valid, overflow); end
    send_word(4'b0110, 1'b0, 1'b0);
    compared++; if (parallel_out !== 4'b1010 || overflow !== 1'b1) begin mismatched++; $display("FAIL bp_drop got %b ovf %b want 1010 1", parallel_out, overflow); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    compared++; if (out_valid !== 1'b0 || overflow !== 1'b1) begin mismatched++; $display("FAIL bp_drain got v %b ovf %b want 0 1", out_valid, overflow); end
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    compared++; if (overflow !== 1'b0) begin mismatched++; $display("FAIL ovf_clr got %b want 0", overflow); end
    // Drop and clear on the same edge: the drop keeps the flag set.
    send_word(4'b0011, 1'b0, 1'b0);
    send_word(4'b0110, 1'b0, 1'b1);
    compared++; if (overflow !== 1'b1 || parallel_out !== 4'b0011) begin mismatched++; $display("FAIL drop_vs_clr got ovf %b po %b want 1 0011", overflow, parallel_out); end
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    compared++; if (overflow !== 1'b0 || out_valid !== 1'b1) begin mismatched++; $display("FAIL clr2 got ovf %b v %b want 0 1", overflow, out_valid); end
  endtask

  task automatic test_back_to_back();
    // 0011 is still pending from the previous test.
    send_word(4'b1001, 1'b1, 1'b0);
    compared++; if (parallel_out !== 4'b1001 || out_valid !== 1'b1) begin mismatched++; $display("FAIL same_edge got %b v %b want 1001 v 1", parallel_out, out_valid); end
    compared++; if (overflow !== 1'b0) begin mismatched++; $display("FAIL same_edge_ovf got %b want 0", overflow); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL same_edge_drain got %b want 0", out_valid); end
  endtask

  task automatic test_lsb_gaps();
    send_bit2(1'b1);
    compared++; if (bit_cnt2 !== 5'd1) begin mismatched++; $display("FAIL lsb_cnt1 got %0d want 1", bit_cnt2); end
    step();
    compared++; if (bit_cnt2 !== 5'd1) begin mismatched++; $display("FAIL lsb_gap_hold got %0d want 1", bit_cnt2); end
    send_bit2(1'b0); step();
    send_bit2(1'b0); step();
    compared++; if (bit_cnt2 !== 5'd3 || out_valid2 !== 1'b0) begin mismatched++; $display("FAIL lsb_cnt3 got %0d v %b want 3 v 0", bit_cnt2, out_valid2); end
    send_bit2(1'b0);
`ifdef SIPO_PARITY_CHECK_EN
    step();
    send_bit2(1'b1);
`endif
    compared++; if (parallel_out2 !== 4'b0001 || out_valid2 !== 1'b1 || bit_cnt2 !== 5'd0) begin mismatched++; $display("FAIL lsb_word got %b v %b cnt %0d want 0001 v 1 cnt 0", parallel_out2, out_valid2, bit_cnt2); end
    out_ready2 = 1'b1;
    send_bit2(1'b1); send_bit2(1'b1); send_bit2(1'b0); send_bit2(1'b1);
`ifdef SIPO_PARITY_CHECK_EN
    send_bit2(1'b1);
`endif
    out_ready2 = 1'b0;
    compared++; if (parallel_out2 !== 4'b1011 || out_valid2 !== 1'b1 || overflow2 !== 1'b0) begin mismatched++; $display("FAIL lsb_word2 got %b v %b ovf %b want 1011 1 0", parallel_out2, out_valid2, overflow2); end
  endtask

  task automatic test_parity();
`ifdef SIPO_PARITY_CHECK_EN
    out_ready = 1'b1;
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    compared++; if (parallel_out !== 4'b1011 || parity_err !== 1'b0) begin mismatched++; $display("FAIL parity_good got %b perr %b want 1011 0", parallel_out, parity_err); end
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    compared++; if (parallel_out !== 4'b1011 || parity_err !== 1'b1 || out_valid !== 1'b1) begin mismatched++; $display("FAIL parity_bad got %b perr %b v %b want 1011 1 1", parallel_out, parity_err, out_valid); end
    out_ready = 1'b0;
`else
    compared++; if (parity_err !== 1'b0 || parity_err2 !== 1'b0) begin mismatched++; $display("FAIL parity_off got %b %b want 0 0", parity_err, parity_err2); end
`endif
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_back_to_back();
    test_lsb_gaps();
    test_parity();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
